// File: rtl/spi_pkg.sv
// Shared SPI definitions: arbiter FSM encoding, index width,
// and default core settings used by every SPI client.
package spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_WRITE,
    S_WAIT_RX,
    S_READ,
    S_GAP,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam int IDX_W = 2;

  localparam logic [1:0] SPIBR_DEF = 2'b00;
  localparam logic [2:0] SPICR_DEF = 3'b000;

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin pick with last-served memory.
// Requester 1 counts as last served after reset, so req0 wins the first tie.
module spi_rr_arb2 (
  input  logic clk,
  input  logic reset_sync2,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic any,
  output logic pick
);

  logic last;

  always_comb begin
    any  = req0 | req1;
    pick = 1'b0;
    if (req0 && req1) begin
      pick = ~last;
    end else if (req1) begin
      pick = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_sync2) begin
    if (!reset_sync2) begin
      last <= 1'b1;
    end else if (take) begin
      last <= pick;
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI core between two requesters: round-robin grant,
// settings load, TX burst, per-byte RX drain with timeout abort.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset_sync2,
  input  logic        req0,
  input  logic        req1,
  input  logic [1:0]  len0,
  input  logic [1:0]  len1,
  input  logic [31:0] tx0,
  input  logic [31:0] tx1,
  input  logic [1:0]  br0,
  input  logic [1:0]  br1,
  input  logic [2:0]  cr0,
  input  logic [2:0]  cr1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err,
  output logic [31:0] rx_data,
  output logic [1:0]  spi_spibr,
  output logic [2:0]  spi_spicr,
  output logic        spi_wr_settings,
  output logic [7:0]  spi_data_in,
  output logic        spi_write_byte,
  output logic        spi_read_byte,
  input  logic [7:0]  spi_data_out,
  input  logic        spi_ready_to_read
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_t state, nxt;
  logic             owner;
  logic [IDX_W-1:0] len_q;
  logic [IDX_W-1:0] idx;
  logic [31:0]      tx_q;
  logic [31:0]      rx_sh;
  logic [31:0]      rx_ins;
  logic [TW-1:0]    tcnt;
  logic             abort;
  logic             any;
  logic             pick;
  logic             take;

  assign take = (state == S_IDLE) && any;

  spi_rr_arb2 u_arb (
    .clk        (clk),
    .reset_sync2(reset_sync2),
    .req0       (req0),
    .req1       (req1),
    .take       (take),
    .any        (any),
    .pick       (pick)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:    if (any) nxt = S_CFG;
      S_CFG:     nxt = S_WRITE;
      S_WRITE:   if (idx == len_q) nxt = S_WAIT_RX;
      S_WAIT_RX: begin
        if (spi_ready_to_read) nxt = S_READ;
        else if (tcnt == TMAX) nxt = S_DONE;
      end
      S_READ:    nxt = S_GAP;
      S_GAP:     nxt = S_CAPTURE;
      S_CAPTURE: nxt = (idx == len_q) ? S_DONE : S_WAIT_RX;
      S_DONE:    nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ins = rx_sh;
    unique case (idx)
      2'd0: rx_ins[31:24] = spi_data_out;
      2'd1: rx_ins[23:16] = spi_data_out;
      2'd2: rx_ins[15:8]  = spi_data_out;
      2'd3: rx_ins[7:0]   = spi_data_out;
    endcase
  end

  always_comb begin
    spi_data_in = '0;
    if (state == S_WRITE) begin
      unique case (idx)
        2'd0: spi_data_in = tx_q[31:24];
        2'd1: spi_data_in = tx_q[23:16];
        2'd2: spi_data_in = tx_q[15:8];
        2'd3: spi_data_in = tx_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_sync2) begin
    if (!reset_sync2) begin
      state     <= S_IDLE;
      owner     <= 1'b0;
      len_q     <= '0;
      tx_q      <= '0;
      idx       <= '0;
      tcnt      <= '0;
      abort     <= 1'b0;
      rx_sh     <= '0;
      rx_data   <= '0;
      spi_spibr <= SPIBR_DEF;
      spi_spicr <= SPICR_DEF;
    end else begin
      state <= nxt;
      unique case (state)
        S_IDLE: if (any) begin
          owner     <= pick;
          len_q     <= pick ? len1 : len0;
          tx_q      <= pick ? tx1 : tx0;
          spi_spibr <= pick ? br1 : br0;
          spi_spicr <= pick ? cr1 : cr0;
          idx       <= '0;
          tcnt      <= '0;
          abort     <= 1'b0;
          rx_sh     <= '0;
        end
        S_WRITE: idx <= (idx == len_q) ? '0 : idx + 2'd1;
        S_WAIT_RX: if (!spi_ready_to_read) begin
          if (tcnt == TMAX) begin
            abort   <= 1'b1;
            rx_data <= rx_sh;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          rx_sh <= rx_ins;
          tcnt  <= '0;
          if (idx == len_q) rx_data <= rx_ins;
          else idx <= idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign gnt0            = (state != S_IDLE) && !owner;
  assign gnt1            = (state != S_IDLE) && owner;
  assign done0           = (state == S_DONE) && !owner;
  assign done1           = (state == S_DONE) && owner;
  assign err             = (state == S_DONE) && abort;
  assign spi_wr_settings = (state == S_CFG);
  assign spi_write_byte  = (state == S_WRITE);
  assign spi_read_byte   = (state == S_READ);

endmodule
